seg_scan_display: RTL and testbench
===================================

// Module: seg_scan_display
// PURPOSE
//   Parametrised time-multiplexed 7-segment driver for N digits: scans one-hot
//   digit commons, decodes 4-bit per-digit values in decimal or hex mode, and
//   supports per-digit decimal points (steady or blinking) and leading-zero
//   blanking. Sits between counter/clock logic and the board's segment pins.
// PARAMETERS
//   DIGITS     4        number of digits scanned; legal 2..8
//   SCAN_DIV   262144   clk cycles each digit stays active; legal >= 2
//   BLINK_DIV  7000000  clk cycles per blink half-period; legal >= 2
// PORTS
//   clk       in   1          system clock, all logic on rising edge
//   rst       in   1          synchronous reset, active-high
//   en        in   1          1 = display active; 0 = blank and hold scan
//   num       in   4*DIGITS   digit values; num[4i+3:4i] = digit i, i=0 least significant
//   dp_on     in   DIGITS     steady decimal point per digit
//   dp_blink  in   DIGITS     1 = digit's point follows blink phase, overrides dp_on
//   hex_mode  in   1          1 = show 0-F; 0 = decimal, values A-F show as 0
//   lz_blank  in   1          1 = blank leading zeros (digit 0 never blanked)
//   com       out  DIGITS     one-hot digit select, active-high
//   light     out  7          segments {a,b,c,d,e,f,g}, 1 = lit
//   dp        out  1          decimal point, 1 = lit
// BEHAVIOUR
//   Reset (rst=1 at clk edge): scan_cnt=0, idx=0, blink_cnt=0, blink_ph=1,
//     com=0, light=0, dp=0. Reset dominates en and all other inputs.
//   Scan counter: when en=1, scan_cnt counts 0..SCAN_DIV-1. At SCAN_DIV-1 it
//     wraps to 0 and idx advances (idx=DIGITS-1 wraps to 0).
//     When en=0: scan_cnt=0, idx=0 (restart from digit 0).
//   Blink counter: free-running regardless of en. At BLINK_DIV-1 it wraps to 0
//     and blink_ph toggles; full blink period = 2*BLINK_DIV cycles.
//   Outputs are registered; one cycle of latency from idx/inputs:
//     en=1: com <= (1<<idx); light <= seg(num digit idx) or 0 if blanked;
//           dp <= dp_blink[idx] ? blink_ph : dp_on[idx].
//     en=0: com <= 0; light <= 0; dp <= 0.
//   num, dp_on, dp_blink, hex_mode and lz_blank are sampled every cycle (live);
//     a change appears on the outputs on the next edge, mid-digit included.
//   Decode (abcdefg): 0 1111110, 1 0110000, 2 1101101, 3 1111001, 4 0110011,
//     5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1111011.
//     hex_mode=1: A 1110111, b 0011111, C 1001110, d 0111101, E 1001111,
//     F 1000111. hex_mode=0: A-F decode as 1111110.
//   Leading-zero blank: digit i (i>=1) blanked when lz_blank=1 and digits
//     i..DIGITS-1 are all 0. Blanked digit: light=0, com still asserted, dp
//     still driven as normal. Digit 0 always displayed.
//   com is always zero or exactly one-hot; never two bits set.
// TESTING  (DIGITS=4, SCAN_DIV=4, BLINK_DIV=10 unless stated)
//   rst=1 2 cycles, en=1 -> com=0,light=0,dp=0 during reset; 1st edge after:
//     com=0001; com=0010 exactly 4 cycles later; order 0001,0010,0100,1000,0001.
//   num=16'h1234, hex_mode=0 -> light per digit: 0110011(4),1111001(3),
//     1101101(2),0110000(1) on com 0001..1000.
//   num=16'h00AF: hex_mode=1 -> digit0 1000111, digit1 1110111; hex_mode=0 ->
//     both 1111110. lz_blank=1, num=16'h0005 -> digits 3..1 light=0, digit0
//     1011011; num=16'h0000 -> only digit0 lit (1111110).
//   dp_blink=4'b0001, dp_on=0 -> dp on digit0 = 1 for first 10 cycles after
//     reset, then 0 for 10, alternating; dp_on=4'b0100 -> steady dp on digit2.
//   en dropped mid-scan on digit 2 -> next edge com=0,light=0,dp=0; en raised
//     -> next edge com=0001, full 4-cycle dwell. rst mid-scan -> same as reset.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit 7-segment driver: one-hot digit scan, decimal/hex decode,
// per-digit steady or blinking decimal points and leading-zero blanking.
module seg_scan_display #(
    parameter int unsigned DIGITS    = 4,
    parameter int unsigned SCAN_DIV  = 262144,
    parameter int unsigned BLINK_DIV = 7000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [4*DIGITS-1:0]   num,
    input  logic [DIGITS-1:0]     dp_on,
    input  logic [DIGITS-1:0]     dp_blink,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [DIGITS-1:0]     com,
    output logic [6:0]            light,
    output logic                  dp
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned IDX_W   = (DIGITS    > 1) ? $clog2(DIGITS)    : 1;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [IDX_W-1:0]   idx;
    logic               blink_ph;

    logic [3:0]         digit_c;
    logic [6:0]         seg_c;
    logic [DIGITS-1:0]  blank_c;
    logic               all_zero_c;

    // Segment pattern {a,b,c,d,e,f,g}; A-F read as zero outside hex mode.
    function automatic logic [6:0] seg_decode(input logic [3:0] v, input logic hex);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1111110;
            4'h1: s = 7'b0110000;
            4'h2: s = 7'b1101101;
            4'h3: s = 7'b1111001;
            4'h4: s = 7'b0110011;
            4'h5: s = 7'b1011011;
            4'h6: s = 7'b1011111;
            4'h7: s = 7'b1110000;
            4'h8: s = 7'b1111111;
            4'h9: s = 7'b1111011;
            4'hA: s = hex ? 7'b1110111 : 7'b1111110;
            4'hB: s = hex ? 7'b0011111 : 7'b1111110;
            4'hC: s = hex ? 7'b1001110 : 7'b1111110;
            4'hD: s = hex ? 7'b0111101 : 7'b1111110;
            4'hE: s = hex ? 7'b1001111 : 7'b1111110;
            default: s = hex ? 7'b1000111 : 7'b1111110;
        endcase
        return s;
    endfunction

    // A digit is blanked when it and every more-significant digit are zero.
    always_comb begin
        blank_c    = '0;
        all_zero_c = 1'b1;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero_c = all_zero_c & (num[4*i +: 4] == 4'h0);
            blank_c[i] = lz_blank & all_zero_c & (i != 0);
        end
    end

    always_comb begin
        digit_c = num[{idx, 2'b00} +: 4];
        seg_c   = blank_c[idx] ? 7'b0000000 : seg_decode(digit_c, hex_mode);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            idx       <= '0;
            blink_cnt <= '0;
            blink_ph  <= 1'b1;
            com       <= '0;
            light     <= '0;
            dp        <= 1'b0;
        end else begin
            // Blink timebase runs even while the display is disabled.
            if (blink_cnt == BLINK_W'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                blink_ph  <= ~blink_ph;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end

            if (en) begin
                if (scan_cnt == SCAN_W'(SCAN_DIV - 1)) begin
                    scan_cnt <= '0;
                    idx      <= (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
                end else begin
                    scan_cnt <= scan_cnt + SCAN_W'(1);
                end
                com   <= DIGITS'(1) << idx;
                light <= seg_c;
                dp    <= dp_blink[idx] ? blink_ph : dp_on[idx];
            end else begin
                scan_cnt <= '0;
                idx      <= '0;
                com      <= '0;
                light    <= '0;
                dp       <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Directed bench for seg_scan_display with DIGITS=4, SCAN_DIV=4, BLINK_DIV=10.
module tb_seg_scan_display;

    localparam logic [6:0] S0 = 7'b1111110;
    localparam logic [6:0] S1 = 7'b0110000;
    localparam logic [6:0] S2 = 7'b1101101;
    localparam logic [6:0] S3 = 7'b1111001;
    localparam logic [6:0] S4 = 7'b0110011;
    localparam logic [6:0] S5 = 7'b1011011;
    localparam logic [6:0] SA = 7'b1110111;
    localparam logic [6:0] SF = 7'b1000111;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [15:0] num;
    logic [3:0]  dp_on;
    logic [3:0]  dp_blink;
    logic        hex_mode;
    logic        lz_blank;
    logic [3:0]  com;
    logic [6:0]  light;
    logic        dp;

    int checks = 0;
    int errors = 0;

    seg_scan_display #(.DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(10)) dut (
        .clk(clk), .rst(rst), .en(en), .num(num), .dp_on(dp_on),
        .dp_blink(dp_blink), .hex_mode(hex_mode), .lz_blank(lz_blank),
        .com(com), .light(light), .dp(dp)
    );

    always #5 clk = ~clk;

    // Advance past one rising edge and stop on the following falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [3:0] c, input logic [6:0] l, input logic d);
        chk({tag, " com"},   8'(com),   8'(c));
        chk({tag, " light"}, 8'(light), 8'(l));
        chk({tag, " dp"},    8'(dp),    8'(d));
    endtask

    initial begin
        logic [6:0] seg_1234 [4];
        int         d;
        logic       exp_dp;

        seg_1234[0] = S4; seg_1234[1] = S3; seg_1234[2] = S2; seg_1234[3] = S1;

        rst = 1'b1; en = 1'b1; num = 16'h1234; dp_on = 4'b0000;
        dp_blink = 4'b0001; hex_mode = 1'b0; lz_blank = 1'b0;

        tick(); chk_out("reset0", 4'b0000, 7'b0, 1'b0);
        tick(); chk_out("reset1", 4'b0000, 7'b0, 1'b0);
        rst = 1'b0;

        // Scan order, 4-cycle dwell, decimal decode and blinking dp on digit 0.
        for (int k = 1; k <= 40; k++) begin
            tick();
            d      = ((k - 1) / 4) % 4;
            exp_dp = (d == 0) ? (((k - 1) / 10) % 2 == 0) : 1'b0;
            chk_out($sformatf("scan%0d", k), 4'(1 << d), seg_1234[d], exp_dp);
        end

        // Drop en while digit 2 is active.
        tick(); chk_out("pre_dis", 4'b0100, S2, 1'b0);
        en = 1'b0;
        tick(); chk_out("dis0", 4'b0000, 7'b0, 1'b0);
        tick(); chk_out("dis1", 4'b0000, 7'b0, 1'b0);

        num = 16'h00AF; hex_mode = 1'b1; dp_blink = 4'b0000; dp_on = 4'b0100; en = 1'b1;
        tick(); chk_out("hexF", 4'b0001, SF, 1'b0);
        tick(); tick(); tick(); chk_out("dwell4", 4'b0001, SF, 1'b0);
        tick(); chk_out("hexA", 4'b0010, SA, 1'b0);
        hex_mode = 1'b0;
        tick(); chk_out("decA", 4'b0010, S0, 1'b0);
        tick(); tick();
        tick(); chk_out("dp_steady0", 4'b0100, S0, 1'b1);
        tick(); tick();
        tick(); chk_out("dp_steady3", 4'b0100, S0, 1'b1);
        tick(); chk_out("dig3_nolz", 4'b1000, S0, 1'b0);

        lz_blank = 1'b1; num = 16'h0005;
        tick(); chk_out("lz_d3", 4'b1000, 7'b0, 1'b0);
        tick(); tick();
        tick(); chk_out("lz_d0", 4'b0001, S5, 1'b0);
        tick(); tick(); tick();
        tick(); chk_out("lz_d1", 4'b0010, 7'b0, 1'b0);
        tick(); tick(); tick();
        tick(); chk_out("lz_d2_dp", 4'b0100, 7'b0, 1'b1);
        num = 16'h0000;
        tick(); tick(); tick();
        tick(); chk_out("lz0_d3", 4'b1000, 7'b0, 1'b0);
        tick(); tick(); tick();
        tick(); chk_out("lz0_d0", 4'b0001, S0, 1'b0);

        // Synchronous reset mid-scan on digit 1.
        tick(); tick(); tick();
        tick(); tick(); chk_out("pre_rst", 4'b0010, 7'b0, 1'b0);
        rst = 1'b1; dp_on = 4'b0000; dp_blink = 4'b0001;
        tick(); chk_out("mid_rst", 4'b0000, 7'b0, 1'b0);
        rst = 1'b0;
        tick(); chk_out("post_rst1", 4'b0001, S0, 1'b1);
        tick(); tick();
        tick(); chk_out("post_rst4", 4'b0001, S0, 1'b1);
        tick(); chk_out("post_rst5", 4'b0010, 7'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
